checkbits_seq_monitor: RTL
==========================

# checkbits_seq_monitor

Synthesizable, parametrised checkpoint-sequence monitor for the `mprj_io[31:16]` checkbits bus. It watches a WIDTH-bit status bus and matches it, in order, against up to DEPTH programmed expected values. Each step has its own cycle timeout and a stability qualifier. It reports per-step hit events with cycle stamps and a final PASS/FAIL, so firmware checkpoint sequences such as a matmul start/result/done can be checked in hardware as well as in simulation.

## Interface
Parameters:
- WIDTH, 16, checkbits width
- DEPTH, 8, max expected values in the sequence
- TIMEOUT_CYCLES, 1000000, per-step timeout in clock cycles (≥2)
- STABLE_CYCLES, 2, consecutive matching samples needed to qualify a hit (≥1)

Ports:
- clock  in  1  sole clock
- RSTB  in  1  asynchronous, active-low reset
- checkbits  in  WIDTH  monitored bus; asynchronous to clock
- cfg_we  in  1  write expected value
- cfg_addr  in  $clog2(DEPTH)  expected-value slot
- cfg_data  in  WIDTH  expected value
- cfg_num  in  $clog2(DEPTH+1)  sequence length, sampled at start
- start  in  1  arm monitor (pulse)
- abort  in  1  return to IDLE
- busy  out  1  state == WAIT
- pass  out  1  sticky sequence pass
- fail  out  1  sticky timeout fail
- step_idx  out  $clog2(DEPTH)  index currently awaited; on FAIL, the failing index
- hit  out  1  one-cycle pulse per qualified match
- hit_idx  out  $clog2(DEPTH)  index matched (valid with hit)
- hit_cycle  out  $clog2(TIMEOUT_CYCLES+1)  cycles since arm or previous hit (valid with hit)

## Operation
- States: IDLE, WAIT, PASS, FAIL. Reset → IDLE. All outputs are 0 on reset. The expected-value memory is cleared to 0.
- cfg_we writes exp[cfg_addr] in IDLE, PASS and FAIL. It is ignored in WAIT.
- start in IDLE, PASS or FAIL with cfg_num in 1..DEPTH moves to WAIT and:
  - latches num = cfg_num;
  - sets idx = 0, timer = 0, stable count = 0;
  - clears pass, fail and hit_cycle.
- start is ignored when cfg_num is 0 or greater than DEPTH, and ignored while in WAIT.
- checkbits passes through a 2-flop synchroniser to give sample s. The stability counter counts consecutive cycles where s == exp[idx]. A mismatch resets it to 0.
- Qualified match: s == exp[idx] and the counter equals STABLE_CYCLES-1. On a qualified match:
  - hit pulses; hit_idx = idx, hit_cycle = timer;
  - idx increments, timer and stable count clear.
  - If idx was num-1, go to PASS and set pass.
- Timeout: in WAIT, the timer increments each cycle. If timer == TIMEOUT_CYCLES-1 with no qualified match that cycle, go to FAIL, set fail, and step_idx holds idx.
- Simultaneous events:
  - qualified match and timeout in the same cycle: the match wins;
  - abort and start together: abort wins;
  - abort in any state → IDLE, clears pass and fail; the memory is kept.
- Intermediate bus values that differ from exp[idx] are ignored; they are not errors.
- A repeated identical expected value needs the bus to be stable for another STABLE_CYCLES after the previous hit. The stable count restarts at 0 after each hit.
- RSTB asserted mid-sequence immediately forces IDLE with all outputs at 0.

## Timing
- checkbits settled before edge k: s is valid after edge k+1. hit asserts after edge k+1+STABLE_CYCLES, for exactly one cycle.
- pass or fail asserts at the same edge as the final hit or the timeout. It then holds until start, abort or reset.
- busy falls at the same edge pass or fail rises.
- start → busy rises at the next edge. Comparison begins the cycle after that.
- The timer saturates at TIMEOUT_CYCLES-1 and never wraps.
- Unsigned width rules:
  - timer width is $clog2(TIMEOUT_CYCLES+1);
  - idx compares against num-1 at full width, so no truncation occurs when num == DEPTH.

## Structure
- The package `checkbits_mon_pkg` holds:
  - the state enum (IDLE, WAIT, PASS, FAIL);
  - localparam width helpers: IDX_W, NUM_W, TMR_W.
- Sub-module `checkbits_sync_stable` contains the 2-flop synchroniser, the equality compare against the presented expected value, and the stability counter. It outputs `qualified`. The top level contains the FSM, timer, expected-value memory and outputs.

## Test plan
- Program AB40, 003E, 0044, 004A, 0050, AB50 with num = 6. Drive each value for 10 cycles, with junk values in between → six hit pulses with hit_idx 0..5, then pass = 1 and fail = 0.
- Program AB40, 003E. Drive AB40 only, with TIMEOUT_CYCLES = 50 → fail at the 50th cycle after the AB40 hit; step_idx = 1, busy = 0.
- STABLE_CYCLES = 3, expected 003E. Apply 2-cycle glitches of 003E → no hit. A 3-cycle hold → hit at the 5th edge after settle.
- Qualified match on the same cycle as the timeout edge → hit, no fail. The sequence continues.
- Assert abort mid-WAIT, then start and abort together → IDLE, pass = fail = 0. Then start alone re-arms with idx 0.
- Assert RSTB low during step 2 → all outputs 0 asynchronously. Start with cfg_num = 0 → busy stays 0.

Source files
------------

// File: rtl/checkbits_mon_pkg.sv
// Shared state encoding and width helpers for the checkbits sequence monitor.
package checkbits_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  // Never returns a zero width, so degenerate parameters still give legal vectors.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 32'd1) ? $clog2(v) : 32'd1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned depth);
    return clog2_min1(depth);
  endfunction

  function automatic int unsigned num_w(input int unsigned depth);
    return clog2_min1(depth + 32'd1);
  endfunction

  function automatic int unsigned tmr_w(input int unsigned timeout);
    return clog2_min1(timeout + 32'd1);
  endfunction

endpackage

// File: rtl/checkbits_sync_stable.sv
// Synchronises the checkbits bus and qualifies a match once it has been
// stable against the presented expected value for STABLE_CYCLES samples.
module checkbits_sync_stable
  import checkbits_mon_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned STABLE_CYCLES = 2,
  localparam int unsigned CNT_W        = clog2_min1(STABLE_CYCLES + 32'd1)
) (
  input  logic             clock,
  input  logic             RSTB,
  input  logic             en,
  input  logic [WIDTH-1:0] checkbits,
  input  logic [WIDTH-1:0] exp_val,
  output logic             qualified
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             match_s;

  // Equality against the current step and the qualify condition.
  always_comb begin
    match_s   = (sync2_q == exp_val);
    qualified = en && match_s && (cnt_q == CNT_W'(STABLE_CYCLES - 32'd1));
  end

  // Two-flop synchroniser and consecutive-match counter; a hit restarts the count.
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= checkbits;
      sync2_q <= sync1_q;
      if (!en || !match_s || qualified) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/checkbits_seq_monitor.sv
// Checkpoint-sequence monitor: matches the checkbits bus in order against a
// programmed list, with a per-step timeout and cycle-stamped hit reporting.
module checkbits_seq_monitor
  import checkbits_mon_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned STABLE_CYCLES  = 2,
  localparam int unsigned IDX_W         = idx_w(DEPTH),
  localparam int unsigned NUM_W         = num_w(DEPTH),
  localparam int unsigned TMR_W         = tmr_w(TIMEOUT_CYCLES)
) (
  input  logic             clock,
  input  logic             RSTB,
  input  logic [WIDTH-1:0] checkbits,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [NUM_W-1:0] cfg_num,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [IDX_W-1:0] step_idx,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic [TMR_W-1:0] hit_cycle
);

  state_e           state_q;
  logic [NUM_W-1:0] num_q;
  logic [IDX_W-1:0] idx_q;
  logic [TMR_W-1:0] timer_q;
  logic [WIDTH-1:0] exp_q [DEPTH];
  logic             busy_q;
  logic             pass_q;
  logic             fail_q;
  logic             hit_q;
  logic [IDX_W-1:0] hit_idx_q;
  logic [TMR_W-1:0] hit_cycle_q;

  logic             qualified_s;
  logic             start_ok_s;
  logic             last_s;
  logic             timeout_s;

  checkbits_sync_stable #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_sync_stable (
    .clock     (clock),
    .RSTB      (RSTB),
    .en        (state_q == WAIT),
    .checkbits (checkbits),
    .exp_val   (exp_q[idx_q]),
    .qualified (qualified_s)
  );

  // Arm, last-step and timeout decodes; last-step compare is done at NUM_W so num == DEPTH fits.
  always_comb begin
    start_ok_s = start && !abort && (state_q != WAIT) &&
                 (cfg_num != '0) && (cfg_num <= NUM_W'(DEPTH));
    last_s     = (NUM_W'(idx_q) == (num_q - NUM_W'(1)));
    timeout_s  = (timer_q == TMR_W'(TIMEOUT_CYCLES - 32'd1));
  end

  // Expected-value memory, writable whenever no sequence is in flight.
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        exp_q[i] <= '0;
      end
    end else if (cfg_we && (state_q != WAIT) && (32'(cfg_addr) < DEPTH)) begin
      exp_q[cfg_addr] <= cfg_data;
    end else begin
      exp_q <= exp_q;
    end
  end

  // Sequencer FSM with timer and registered status outputs.
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      state_q     <= IDLE;
      num_q       <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      hit_cycle_q <= '0;
    end else begin
      hit_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        idx_q   <= '0;
        timer_q <= '0;
        busy_q  <= 1'b0;
        pass_q  <= 1'b0;
        fail_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, PASS, FAIL: begin
            if (start_ok_s) begin
              state_q     <= WAIT;
              num_q       <= cfg_num;
              idx_q       <= '0;
              timer_q     <= '0;
              busy_q      <= 1'b1;
              pass_q      <= 1'b0;
              fail_q      <= 1'b0;
              hit_cycle_q <= '0;
            end
          end
          WAIT: begin
            // A match on the timeout cycle takes priority over the timeout.
            if (qualified_s) begin
              hit_q       <= 1'b1;
              hit_idx_q   <= idx_q;
              hit_cycle_q <= timer_q;
              timer_q     <= '0;
              if (last_s) begin
                state_q <= PASS;
                busy_q  <= 1'b0;
                pass_q  <= 1'b1;
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end else if (timeout_s) begin
              state_q <= FAIL;
              busy_q  <= 1'b0;
              fail_q  <= 1'b1;
            end else begin
              timer_q <= timer_q + TMR_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign step_idx  = idx_q;
  assign hit       = hit_q;
  assign hit_idx   = hit_idx_q;
  assign hit_cycle = hit_cycle_q;

endmodule
